// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential floating-point multiplier.
package fp_pkg;

    localparam int unsigned EXP_W_DEF  = 8;
    localparam int unsigned FRAC_W_DEF = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_OUT
    } fp_state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [127:0] qnan_word(input int unsigned exp_w, input int unsigned frac_w);
        logic [127:0] w;
        w = ((128'(1) << exp_w) - 128'(1)) << frac_w;
        w = w | (128'(1) << (frac_w - 1));
        return w;
    endfunction

endpackage

// File: rtl/fp_unpack_class.sv
// Field split, hidden-bit insertion and classification of one operand (FTZ).
module fp_unpack_class
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
    input  logic [W-1:0]      word,
    output logic              sign_c,
    output logic [EXP_W-1:0]  exp_c,
    output logic [FRAC_W:0]   man_c,
    output fp_class_e         cls_c
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign sign_c = word[W-1];
    assign exp_f  = word[W-2 -: EXP_W];
    assign frac_f = word[FRAC_W-1:0];

    // Zero (including flushed subnormals), inf, NaN or normal.
    always_comb begin
        exp_c = exp_f;
        man_c = '0;
        cls_c = CLS_NORM;
        if (exp_f == '0) begin
            cls_c = CLS_ZERO;
        end else if (exp_f == '1) begin
            cls_c = (frac_f == '0) ? CLS_INF : CLS_NAN;
        end else begin
            man_c = {1'b1, frac_f};
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle FP multiplier: unpack, multiply, normalise, round (RNE), pack.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  input_a,
    input  logic [W-1:0]  input_b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  output_z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          flag_invalid,
    output logic          flag_overflow,
    output logic          flag_underflow,
    output logic          flag_inexact
);

    localparam int unsigned BIAS = 2**(EXP_W-1) - 1;
    localparam int unsigned MW   = FRAC_W + 1;
    localparam int unsigned MW1  = MW + 1;
    localparam int unsigned PW   = 2 * MW;
    localparam int unsigned EW   = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_INF = EW'((2**EXP_W) - 1);
    localparam logic [W-1:0] QNAN = W'(qnan_word(EXP_W, FRAC_W));

    fp_state_e state;
    logic [W-1:0] op_a, op_b;

    logic             ua_sign, ub_sign;
    logic [EXP_W-1:0] ua_exp, ub_exp;
    logic [MW-1:0]    ua_man, ub_man;
    fp_class_e        ua_cls, ub_cls;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MW-1:0]    ma, mb;
    fp_class_e        ca, cb;

    logic [PW-1:0]        prod;
    logic signed [EW-1:0] exp_m;
    logic                 sign_m, sp_nan, sp_inf, sp_zero;

    logic [MW-1:0]        man_n;
    logic                 g_n, r_n, s_n;
    logic signed [EW-1:0] exp_n;

    logic [PW-1:0]        norm_c;
    logic                 inc_c;
    logic [MW:0]          sum_c;
    logic signed [EW-1:0] exp_r_c;
    logic [FRAC_W-1:0]    frac_r_c;
    logic [W-1:0]         z_c;
    logic                 invalid_c, overflow_c, underflow_c, inexact_c;

    fp_unpack_class #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_a (
        .word(op_a), .sign_c(ua_sign), .exp_c(ua_exp), .man_c(ua_man), .cls_c(ua_cls)
    );

    fp_unpack_class #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_b (
        .word(op_b), .sign_c(ub_sign), .exp_c(ub_exp), .man_c(ub_man), .cls_c(ub_cls)
    );

    // Align product so the leading one sits at the MSB.
    assign norm_c = prod[PW-1] ? prod : (prod << 1);

    // Round to nearest even and choose the final packed result and flags.
    always_comb begin
        inc_c       = g_n & (r_n | s_n | man_n[0]);
        sum_c       = {1'b0, man_n} + MW1'(inc_c);
        exp_r_c     = sum_c[MW] ? (exp_n + $signed(EW'(1))) : exp_n;
        frac_r_c    = sum_c[MW] ? sum_c[FRAC_W:1] : sum_c[FRAC_W-1:0];
        z_c         = {sign_m, exp_r_c[EXP_W-1:0], frac_r_c};
        invalid_c   = 1'b0;
        overflow_c  = 1'b0;
        underflow_c = 1'b0;
        inexact_c   = 1'b0;
        if (sp_nan) begin
            z_c       = QNAN;
            invalid_c = 1'b1;
        end else if (sp_inf) begin
            z_c = {sign_m, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (sp_zero) begin
            z_c = {sign_m, {(W-1){1'b0}}};
        end else if (exp_r_c >= EXP_INF) begin
            z_c        = {sign_m, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            overflow_c = 1'b1;
            inexact_c  = 1'b1;
        end else if (exp_r_c <= $signed(EW'(0))) begin
            z_c         = {sign_m, {(W-1){1'b0}}};
            underflow_c = 1'b1;
            inexact_c   = 1'b1;
        end else begin
            inexact_c = g_n | r_n | s_n;
        end
    end

    // Control FSM and pipeline registers, one stage per state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            output_z       <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            sa             <= 1'b0;
            sb             <= 1'b0;
            ea             <= '0;
            eb             <= '0;
            ma             <= '0;
            mb             <= '0;
            ca             <= CLS_ZERO;
            cb             <= CLS_ZERO;
            prod           <= '0;
            exp_m          <= '0;
            sign_m         <= 1'b0;
            sp_nan         <= 1'b0;
            sp_inf         <= 1'b0;
            sp_zero        <= 1'b0;
            man_n          <= '0;
            g_n            <= 1'b0;
            r_n            <= 1'b0;
            s_n            <= 1'b0;
            exp_n          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= input_a;
                        op_b     <= input_b;
                        in_ready <= 1'b0;
                        state    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sa    <= ua_sign;
                    sb    <= ub_sign;
                    ea    <= ua_exp;
                    eb    <= ub_exp;
                    ma    <= ua_man;
                    mb    <= ub_man;
                    ca    <= ua_cls;
                    cb    <= ub_cls;
                    state <= S_MULT;
                end
                S_MULT: begin
                    prod    <= PW'(ma) * PW'(mb);
                    exp_m   <= $signed(EW'(ea)) + $signed(EW'(eb)) - $signed(EW'(BIAS));
                    sign_m  <= sa ^ sb;
                    sp_nan  <= (ca == CLS_NAN) || (cb == CLS_NAN) ||
                               ((ca == CLS_INF) && (cb == CLS_ZERO)) ||
                               ((ca == CLS_ZERO) && (cb == CLS_INF));
                    sp_inf  <= (ca == CLS_INF) || (cb == CLS_INF);
                    sp_zero <= (ca == CLS_ZERO) || (cb == CLS_ZERO);
                    state   <= S_NORM;
                end
                S_NORM: begin
                    man_n <= norm_c[PW-1 -: MW];
                    g_n   <= norm_c[PW-1-MW];
                    r_n   <= norm_c[PW-2-MW];
                    s_n   <= |norm_c[PW-3-MW:0];
                    exp_n <= prod[PW-1] ? (exp_m + $signed(EW'(1))) : exp_m;
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    output_z       <= z_c;
                    flag_invalid   <= invalid_c;
                    flag_overflow  <= overflow_c;
                    flag_underflow <= underflow_c;
                    flag_inexact   <= inexact_c;
                    out_valid      <= 1'b1;
                    state          <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq (single precision).
module tb_fp_mul_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] input_a, input_b;
    logic         in_valid, in_ready;
    logic [W-1:0] output_z;
    logic         out_valid, out_ready;
    logic         flag_invalid, flag_overflow, flag_underflow, flag_inexact;
    logic [3:0]   flags;

    int errors = 0;
    int checks = 0;

    assign flags = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};

    always #5 clk = ~clk;

    fp_mul_seq #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_b(input_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .output_z(output_z), .out_valid(out_valid), .out_ready(out_ready),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present operands and complete the input handshake on the next edge.
    task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        input_a  = a;
        input_b  = b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the handshake to the first edge that samples out_valid high.
    task automatic wait_valid(output int cnt);
        logic v;
        cnt = 0;
        v   = 1'b0;
        while (!v && cnt < 20) begin
            @(negedge clk);
            v = out_valid;
            @(posedge clk);
            cnt++;
        end
        #1;
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ir_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ez, input logic [3:0] ef);
        int lat;
        send(tag, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'd5);
        check({tag, "_z"}, 64'(output_z), 64'(ez));
        check({tag, "_flags"}, 64'(flags), 64'(ef));
        take(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        rst       = 1'b0;
        input_a   = '0;
        input_b   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_z", 64'(output_z), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // flags = {invalid, overflow, underflow, inexact}
        run_op("mul3x2",   32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
        run_op("rnd_down", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_op("exact",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        run_op("inf_x0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_op("ninf_x2",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        run_op("subn",     32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000);
        run_op("ovf",      32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        run_op("unf",      32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        run_op("nan_op",   32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_op("neg_mul",  32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000);

        // Backpressure: hold the result, ignore new operands while busy.
        send("bp", 32'h40400000, 32'h40000000);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2 && i < 5) begin
                input_a  = 32'h3F800000;
                input_b  = 32'h3F800000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_z", 64'(output_z), 64'h40C00000);
            check("bp_flags", 64'(flags), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        take("bp");
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("bp_no_extra", 64'(seen), 64'd0);

        // Reset in the MULT cycle aborts the operation.
        send("rmid", 32'h40400000, 32'h40000000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rmid_out_valid", 64'(out_valid), 64'd0);
        check("rmid_in_ready", 64'(in_ready), 64'd1);
        check("rmid_z", 64'(output_z), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("rmid_no_stale", 64'(seen), 64'd0);

        run_op("post_rst", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
